// File: rtl/fp_norm_pkg.sv
// Shared widths, limits and the stage-1 payload for the 27-bit post-add normalizer.
package fp_norm_pkg;
  localparam int MANT_W  = 27;
  localparam int EXP_W   = 8;
  localparam int CNT_W   = 5;
  localparam int EXP_MAX = 255;
  localparam int CNT_MAX = 26;
  localparam int RES_W   = 10;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [2:0]        shift_lo;
    logic [EXP_W-1:0]  exp;
    logic              zero;
    logic              uflow;
    logic              ovf;
  } s1_payload_t;
endpackage

// File: rtl/fp_norm_shift27_lshift_stage.sv
// Combinational left shift by amt*STEP positions, zero-filled, overflow bits dropped.
module lshift_stage
  import fp_norm_pkg::*;
#(
  parameter int STEP = 1,
  parameter int SH_W = 3
) (
  input  logic [MANT_W-1:0] din,
  input  logic [SH_W-1:0]   amt,
  output logic [MANT_W-1:0] dout
);
  assign dout = din << (32'(amt) * STEP);
endmodule

// File: rtl/fp_norm_shift27.sv
// Two-stage normalizer: coarse (x8) shift + exponent/flag decode, then fine (x1) shift.
module fp_norm_shift27
  import fp_norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              zero_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero_out,
  output logic              uflow_out,
  output logic              ovf_out
);
  // Handshake: a beat moves when valid & ready are both high at a clk edge.
  // Each stage advances when it is empty or the stage after it advances;
  // in_ready is stage-1's advance condition, so it depends combinationally on out_ready.
  s1_payload_t       s1_q, s1_d, s1_new;
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic              s1_adv, s2_adv;
  logic [RES_W-1:0]  res;
  logic              zero_case, uflow_case, ovf_case;
  logic [CNT_W-1:0]  shamt;
  logic [MANT_W-1:0] mant_sel, mant_coarse, mant_fine;
  logic [MANT_W-1:0] mant_out_q, mant_out_d;
  logic [EXP_W-1:0]  exp_out_q, exp_out_d;
  logic              zero_q, zero_d, uflow_q, uflow_d, ovf_q, ovf_d;

  // res is two's complement; bit RES_W-1 set means negative.
  always_comb begin
    res        = RES_W'(exp_in) + RES_W'(1) - RES_W'(cnt_in);
    zero_case  = zero_in | (cnt_in > CNT_W'(CNT_MAX));
    uflow_case = !zero_case & (res[RES_W-1] | (res == '0));
    ovf_case   = !zero_case & !uflow_case & (res >= RES_W'(EXP_MAX));
    shamt      = uflow_case ? exp_in[CNT_W-1:0] : cnt_in;
    mant_sel   = (zero_case | ovf_case) ? '0 : mant_in;
  end

  lshift_stage #(.STEP(8), .SH_W(2)) u_coarse (
    .din (mant_sel),
    .amt (shamt[4:3]),
    .dout(mant_coarse)
  );

  always_comb begin
    s1_new          = '0;
    s1_new.mant     = mant_coarse;
    s1_new.shift_lo = shamt[2:0];
    s1_new.zero     = zero_case;
    s1_new.uflow    = uflow_case;
    s1_new.ovf      = ovf_case;
    if (ovf_case) s1_new.exp = EXP_W'(EXP_MAX);
    else if (!zero_case && !uflow_case) s1_new.exp = res[EXP_W-1:0];
  end

  lshift_stage #(.STEP(1), .SH_W(3)) u_fine (
    .din (s1_q.mant),
    .amt (s1_q.shift_lo),
    .dout(mant_fine)
  );

  always_comb begin
    s2_adv     = !s2_valid_q | out_ready;
    s1_adv     = !s1_valid_q | s2_adv;
    in_ready   = s1_adv;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    mant_out_d = mant_out_q;
    exp_out_d  = exp_out_q;
    zero_d     = zero_q;
    uflow_d    = uflow_q;
    ovf_d      = ovf_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = s1_new;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        mant_out_d = mant_fine;
        exp_out_d  = s1_q.exp;
        zero_d     = s1_q.zero;
        uflow_d    = s1_q.uflow;
        ovf_d      = s1_q.ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      mant_out_q <= '0;
      exp_out_q  <= '0;
      zero_q     <= 1'b0;
      uflow_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      mant_out_q <= mant_out_d;
      exp_out_q  <= exp_out_d;
      zero_q     <= zero_d;
      uflow_q    <= uflow_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign mant_out  = mant_out_q;
  assign exp_out   = exp_out_q;
  assign zero_out  = zero_q;
  assign uflow_out = uflow_q;
  assign ovf_out   = ovf_q;
endmodule

// File: tb/tb_fp_norm_shift27.sv
// Bench for fp_norm_shift27: directed table, stall/reset sequences, random traffic vs model.
module tb_fp_norm_shift27;
  localparam int W = 38;  // {mant[26:0], exp[7:0], zero, uflow, ovf}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] mant_in = '0;
  logic [4:0]  cnt_in = '0;
  logic        zero_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [26:0] mant_out;
  logic [7:0]  exp_out;
  logic        zero_out, uflow_out, ovf_out;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  fp_norm_shift27 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .cnt_in(cnt_in), .zero_in(zero_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready), .mant_out(mant_out),
    .exp_out(exp_out), .zero_out(zero_out), .uflow_out(uflow_out), .ovf_out(ovf_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [26:0] m, input logic [4:0] c,
                                         input logic z, input logic [7:0] e);
    int res;
    longint unsigned wide;
    res = int'(e) + 1 - int'(c);
    if (z || c > 26) return {27'd0, 8'd0, 3'b100};
    wide = 64'(m);
    if (res <= 0) begin
      wide = wide << e;
      return {wide[26:0], 8'd0, 3'b010};
    end
    if (res >= 255) return {27'd0, 8'd255, 3'b001};
    wide = wide << c;
    return {wide[26:0], 8'(res), 3'b000};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [26:0] m, input logic [4:0] c, input logic z,
                      input logic [7:0] e, input logic push);
    int waits = 0;
    mant_in = m; cnt_in = c; zero_in = z; exp_in = e; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      compared++; mismatched++;
      $display("FAIL send_timeout got=in_ready0 want=in_ready1 at %0t", $time);
    end else if (push) begin
      exp_q.push_back(model(m, c, z, e));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard / stall monitor ----------------
  logic [W-1:0] held_v;
  logic         stalled = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] cur, want;
    cur = {mant_out, exp_out, zero_out, uflow_out, ovf_out};
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        compared++;
        if (!out_valid || cur !== held_v) begin
          mismatched++;
          $display("FAIL stall_hold got=%0b/%0h want=1/%0h at %0t", out_valid, cur, held_v, $time);
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_beat got=%0h want=none at %0t", cur, $time);
        end else begin
          want = exp_q.pop_front();
          if (cur !== want) begin
            mismatched++;
            $display("FAIL out_beat got mant=%h exp=%0d zuo=%b want mant=%h exp=%0d zuo=%b",
                     cur[37:11], cur[10:3], cur[2:0], want[37:11], want[10:3], want[2:0]);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held_v  = cur;
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [26:0]  mant;
    logic [4:0]   cnt;
    logic         zero;
    logic [7:0]   exp;
    logic [W-1:0] expv;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [26:0] m;
    logic [4:0]  c;
    logic [7:0]  e;
    longint unsigned top, r;
    bit done;

    tbl[0] = '{27'h0400000, 5'd4,  1'b0, 8'd100, {27'h4000000, 8'd97,  3'b000}};
    tbl[1] = '{27'h4000001, 5'd0,  1'b0, 8'd100, {27'h4000001, 8'd101, 3'b000}};
    tbl[2] = '{27'h0000001, 5'd26, 1'b0, 8'd3,   {27'h0000008, 8'd0,   3'b010}};
    tbl[3] = '{27'h4000000, 5'd0,  1'b0, 8'd254, {27'h0000000, 8'd255, 3'b001}};
    tbl[4] = '{27'h1234567, 5'd2,  1'b1, 8'd77,  {27'h0000000, 8'd0,   3'b100}};
    tbl[5] = '{27'h0000001, 5'd26, 1'b0, 8'd26,  {27'h4000000, 8'd1,   3'b000}};

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({mant_out, exp_out, zero_out, uflow_out, ovf_out}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // ---- table with latency checks ----
    for (int i = 0; i < 6; i++) begin
      mant_in = tbl[i].mant; cnt_in = tbl[i].cnt; zero_in = tbl[i].zero; exp_in = tbl[i].exp;
      in_valid = 1'b1;
      exp_q.push_back(tbl[i].expv);
      @(negedge clk);
      chk("tbl_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_cycle2", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end

    // ---- backpressure: 4 beats, out_ready low for 6 cycles ----
    out_ready = 1'b0;
    fork
      begin
        send(27'h0800000, 5'd3, 1'b0, 8'd50, 1'b1);
        send(27'h0000100, 5'd18, 1'b0, 8'd60, 1'b1);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        send(27'h2000000, 5'd1, 1'b0, 8'd200, 1'b1);
        send(27'h0000003, 5'd25, 1'b0, 8'd10, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1 chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // ---- reset with two beats in flight ----
    out_ready = 1'b0;
    send(27'h0400000, 5'd4, 1'b0, 8'd100, 1'b0);
    send(27'h0000001, 5'd26, 1'b0, 8'd3, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outputs", 64'({mant_out, exp_out, zero_out, uflow_out, ovf_out}), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // ---- random traffic with random backpressure ----
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          c = 5'($urandom_range(0, 31));
          case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(0, 30));
            1:       e = 8'($urandom_range(225, 255));
            default: e = 8'($urandom_range(0, 255));
          endcase
          if (c <= 26) begin
            top = 64'd1 << (26 - c);
            r = 64'($urandom);
            r = (r & (top - 1)) | top;
            m = r[26:0];
          end else begin
            m = 27'($urandom);
          end
          send(m, c, ($urandom_range(0, 15) == 0), e, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    begin
      int guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
        @(posedge clk);
        guard++;
      end
    end
    #1 chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fp_norm_shift27.md
Name: fp_norm_shift27

Overview:
- Two-stage pipelined normalizer. It is the consumer end of the 27-bit leading-zero encoder interface.
- Takes the raw 27-bit adder mantissa, the encoder's 5-bit leading-zero count and zero flag, and the pre-normalization exponent.
- Left-shifts the mantissa by the count, adjusts the exponent, and flags zero, underflow and overflow.
- Sits between the encoder and the rounding stage of the FP adder. Valid/ready handshake on both sides.

Parameters:
- MANT_W, 27, mantissa width (bit 26 = carry position).
- EXP_W, 8, exponent width.
- CNT_W, 5, shift-count width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept input this cycle.
- mant_in  input  27  unnormalized mantissa.
- cnt_in  input  5  leading-zero count: 0 means bit 26 set, 26 means only bit 0 set.
- zero_in  input  1  mantissa is all zero.
- exp_in  input  8  biased exponent before normalization.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts output.
- mant_out  output  27  normalized mantissa.
- exp_out  output  8  adjusted exponent.
- zero_out  output  1  result is zero.
- uflow_out  output  1  result is denormal/underflow.
- ovf_out  output  1  exponent overflow (infinity).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state: on rst_n=0 at a clk edge, both stage valids clear. out_valid=0; mant_out, exp_out, zero_out, uflow_out and ovf_out are all 0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded, never emitted.
- Exponent arithmetic: res = exp_in + 1 - cnt_in, computed 10-bit signed.
- Zero case (zero_in=1, or cnt_in > 26): mant_out=0, exp_out=0, zero_out=1, uflow=ovf=0.
- Underflow (res <= 0, not zero): uflow_out=1, exp_out=0. Shift amount is clamped to s = exp_in[4:0]; exp_in < cnt_in <= 26 guarantees it fits.
- Overflow (res >= 255): ovf_out=1, exp_out=255, mant_out=0.
- Normal case: s = cnt_in, exp_out = res[7:0], flags 0.
- Stage 1: registers the mantissa shifted left by s[4:3]*8, plus s[2:0], the result exponent and the flags.
- Stage 2: shifts left by s[2:0] and registers the outputs. Zero-filled from the LSB; bits shifted past bit 26 are dropped.
- Latency: exactly 2 cycles from an accepted input to out_valid when unstalled. Throughput is 1 beat per cycle.
- Handshake:
  - Input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
  - s2 advances when !s2_valid | out_ready. s1 advances when !s1_valid | s2 advances.
  - in_ready = s1 advance condition (combinational from out_ready; no skid buffer).
- Stall behaviour: under stall, outputs hold stable while out_valid=1 & out_ready=0. No beat is lost, duplicated or reordered. Two beats maximum in flight.
- Simultaneous accept and consume in one cycle is legal and keeps full throughput.

Decomposition:
- Package fp_norm_pkg holds:
  - MANT_W, EXP_W, CNT_W, EXP_MAX=255, CNT_MAX=26.
  - A struct for the stage-1 payload: mant, shift-low, exp, zero, uflow, ovf.
- Sub-module lshift_stage: purely combinational left shift of a MANT_W vector by a selectable amount. Instantiated once per stage, with step 8 granularity in stage 1 and step 1 in stage 2.

Test Plan:
- Normal case: mant_in=27'h0400000, cnt=4, exp=100, out_ready=1 -> two cycles later mant_out=27'h4000000, exp_out=97, all flags 0.
- Carry case: mant_in=27'h4000001, cnt=0, exp=100 -> mant_out=27'h4000001, exp_out=101.
- Underflow: mant_in=27'h0000001, cnt=26, exp=3 -> uflow_out=1, exp_out=0, mant_out=27'h0000008.
- Overflow and zero: cnt=0, exp=254 -> ovf_out=1, exp_out=255, mant_out=0. Then zero_in=1, exp=77 -> zero_out=1, exp_out=0, mant_out=0.
- Backpressure: 4 back-to-back beats with out_ready=0 for 6 cycles -> in_ready drops after 2 beats are held, outputs stay stable; on out_ready=1 all 4 emerge in order with no gaps or duplicates.
- Reset mid-flight: rst_n=0 for one cycle with 2 beats in flight -> next cycle out_valid=0, all outputs 0, in_ready=1; the beats are never emitted.
